// File: rtl/sys_types_pkg.sv
// Shared datapath types: int8 activations, 128-bit chunk payloads and the packer state encoding.
package sys_types;

  typedef logic signed [7:0] int8_t;

  localparam int unsigned CHUNK_BITS  = 128;
  localparam int unsigned CHUNK_BYTES = CHUNK_BITS / 8;

  // One activation-memory word; lane i occupies bits [8*i +: 8] on both pack and unpack sides.
  typedef logic [CHUNK_BITS-1:0] chunk_t;

  typedef enum logic [1:0] {
    PACK_IDLE     = 2'd0,
    PACK_FILL     = 2'd1,
    PACK_WRITE    = 2'd2,
    PACK_COMPLETE = 2'd3
  } pack_state_e;

endpackage

// File: rtl/chunk_packer.sv
// Packs an int8 value stream into 128-bit chunks and writes one chunk per 16 values.
// Optional early-termination input `flush` is enabled by defining CHUNK_PACKER_FLUSH_EN.
module chunk_packer
  import sys_types::*;
#(
  parameter int unsigned TOTAL_VALUES = 256,
  parameter int unsigned CHUNK_SIZE   = 16,
  parameter int unsigned TOTAL_CHUNKS = TOTAL_VALUES / CHUNK_SIZE,
  localparam int unsigned VALUE_AW = (TOTAL_VALUES > 1) ? $clog2(TOTAL_VALUES) : 1,
  localparam int unsigned CHUNK_AW = (TOTAL_CHUNKS > 1) ? $clog2(TOTAL_CHUNKS) : 1,
  localparam int unsigned BYTE_AW  = $clog2(CHUNK_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_pack,
  input  int8_t                 in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [VALUE_AW-1:0]   in_addr,
  output logic                  write_req,
  output logic [CHUNK_AW-1:0]   write_addr,
  output logic [CHUNK_BITS-1:0] write_data,
  input  logic                  write_ack,
`ifdef CHUNK_PACKER_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  pack_complete
);

  pack_state_e         state_q, state_n;
  logic [BYTE_AW-1:0]  byte_idx_q, byte_idx_n;
  logic [VALUE_AW-1:0] value_addr_q, value_addr_n;
  logic [CHUNK_AW-1:0] chunk_addr_q, chunk_addr_n;
  chunk_t              buf_q, buf_n;
  logic                flushing_q, flushing_n;
  logic                flush_c;
  logic                last_lane_c;
  logic                last_chunk_c;

`ifdef CHUNK_PACKER_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign last_lane_c  = (byte_idx_q == BYTE_AW'(CHUNK_SIZE - 1));
  assign last_chunk_c = (chunk_addr_q == CHUNK_AW'(TOTAL_CHUNKS - 1));

  // Next-state and datapath update; in_ready is high exactly while in FILL.
  always_comb begin
    state_n      = state_q;
    byte_idx_n   = byte_idx_q;
    value_addr_n = value_addr_q;
    chunk_addr_n = chunk_addr_q;
    buf_n        = buf_q;
    flushing_n   = flushing_q;

    case (state_q)
      PACK_IDLE: begin
        byte_idx_n   = '0;
        value_addr_n = '0;
        chunk_addr_n = '0;
        buf_n        = '0;
        flushing_n   = 1'b0;
        if (start_pack) begin
          state_n = PACK_FILL;
        end
      end

      PACK_FILL: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < CHUNK_BYTES; i++) begin
            if (byte_idx_q == BYTE_AW'(i)) begin
              buf_n[i*8 +: 8] = in_data;
            end
          end
          byte_idx_n   = byte_idx_q + BYTE_AW'(1);
          value_addr_n = value_addr_q + VALUE_AW'(1);
          if (last_lane_c) begin
            state_n = PACK_WRITE;
          end
        end
        // A flush stores any coincident value first, then writes the partial chunk.
        if (flush_c) begin
          if (in_valid || (byte_idx_q != '0)) begin
            state_n    = PACK_WRITE;
            flushing_n = 1'b1;
          end else begin
            state_n = PACK_COMPLETE;
          end
        end
      end

      PACK_WRITE: begin
        if (write_ack) begin
          if (last_chunk_c || flushing_q) begin
            state_n = PACK_COMPLETE;
          end else begin
            state_n      = PACK_FILL;
            chunk_addr_n = chunk_addr_q + CHUNK_AW'(1);
            byte_idx_n   = '0;
            buf_n        = '0;
          end
        end
      end

      PACK_COMPLETE: begin
        if (start_pack) begin
          state_n      = PACK_FILL;
          byte_idx_n   = '0;
          value_addr_n = '0;
          chunk_addr_n = '0;
          buf_n        = '0;
          flushing_n   = 1'b0;
        end
      end

      default: begin
        state_n = PACK_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PACK_IDLE;
      byte_idx_q    <= '0;
      value_addr_q  <= '0;
      chunk_addr_q  <= '0;
      buf_q         <= '0;
      flushing_q    <= 1'b0;
      in_ready      <= 1'b0;
      write_req     <= 1'b0;
      pack_complete <= 1'b0;
    end else begin
      state_q       <= state_n;
      byte_idx_q    <= byte_idx_n;
      value_addr_q  <= value_addr_n;
      chunk_addr_q  <= chunk_addr_n;
      buf_q         <= buf_n;
      flushing_q    <= flushing_n;
      in_ready      <= (state_n == PACK_FILL);
      write_req     <= (state_n == PACK_WRITE);
      pack_complete <= (state_n == PACK_COMPLETE);
    end
  end

  assign in_addr    = value_addr_q;
  assign write_addr = chunk_addr_q;
  assign write_data = buf_q;

endmodule

// File: tb/tb_chunk_packer.sv
// Self-checking bench for chunk_packer: randomized streams against a value-queue reference model.
module tb_chunk_packer;

  localparam int TOTAL_VALUES = 256;
  localparam int CHUNK_SIZE   = 16;
  localparam int TOTAL_CHUNKS = TOTAL_VALUES / CHUNK_SIZE;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_pack;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_addr;
  logic         write_req;
  logic [3:0]   write_addr;
  logic [127:0] write_data;
  logic         write_ack;
  logic         flush;
  logic         pack_complete;

  int n_pass   = 0;
  int n_checks = 0;

  chunk_packer dut (
    .clk           (clk),
    .reset         (reset),
    .start_pack    (start_pack),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .write_req     (write_req),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .write_ack     (write_ack),
`ifdef CHUNK_PACKER_FLUSH_EN
    .flush         (flush),
`endif
    .pack_complete (pack_complete)
  );

  always #5 clk = ~clk;

  // Streams one full pass; the model is the list of accepted values, chunk c = values[16c +: 16].
  task automatic run_pass(input int valid_mode, input int ack_mode, input bit seq_data,
                          input bit noise, input string tag);
    logic [7:0]   vals[$];
    logic [127:0] exp_data;
    logic [7:0]   d;
    int  accepted = 0;
    int  chunks   = 0;
    int  wait_cnt = 0;
    int  target   = 0;
    int  cyc      = 0;
    bit  alt      = 1'b0;
    bit  exp_w, exp_r, exp_c, v;
    target = (ack_mode == 0) ? 0 : (ack_mode == 1) ? 5 : int'($urandom_range(0, 4));
    @(negedge clk);
    start_pack = 1'b1;
    @(negedge clk);
    start_pack = 1'b0;
    forever begin
      exp_w = (accepted == CHUNK_SIZE * (chunks + 1));
      exp_c = (chunks == TOTAL_CHUNKS);
      exp_r = !exp_w && !exp_c;
      n_checks++;
      if (in_ready !== exp_r) $display("FAIL %s in_ready cyc %0d: got %b expected %b", tag, cyc, in_ready, exp_r);
      else n_pass++;
      n_checks++;
      if (write_req !== exp_w) $display("FAIL %s write_req cyc %0d: got %b expected %b", tag, cyc, write_req, exp_w);
      else n_pass++;
      n_checks++;
      if (pack_complete !== exp_c) $display("FAIL %s pack_complete cyc %0d: got %b expected %b", tag, cyc, pack_complete, exp_c);
      else n_pass++;
      n_checks++;
      if (in_addr !== 8'(accepted)) $display("FAIL %s in_addr cyc %0d: got %0d expected %0d", tag, cyc, in_addr, 8'(accepted));
      else n_pass++;
      if (exp_w) begin
        exp_data = '0;
        for (int i = 0; i < CHUNK_SIZE; i++) exp_data[i*8 +: 8] = vals[CHUNK_SIZE * chunks + i];
        n_checks++;
        if (write_addr !== 4'(chunks)) $display("FAIL %s write_addr: got %0d expected %0d", tag, write_addr, chunks);
        else n_pass++;
        n_checks++;
        if (write_data !== exp_data) $display("FAIL %s write_data chunk %0d: got %h expected %h", tag, chunks, write_data, exp_data);
        else n_pass++;
      end
      if (exp_c) break;

      write_ack  = 1'b0;
      start_pack = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      if (exp_w) begin
        in_valid = 1'b1;
        in_data  = 8'hEE;
        if (wait_cnt >= target) begin
          write_ack = 1'b1;
          chunks++;
          wait_cnt = 0;
          target = (ack_mode == 0) ? 0 : (ack_mode == 1) ? 5 : int'($urandom_range(0, 4));
        end else begin
          wait_cnt++;
        end
      end else begin
        alt = ~alt;
        v = (valid_mode == 0) ? 1'b1 : (valid_mode == 1) ? alt : ($urandom_range(0, 2) != 0);
        if (v) begin
          d = seq_data ? 8'(accepted) : 8'($urandom);
          in_valid = 1'b1;
          in_data  = d;
          vals.push_back(d);
          accepted++;
        end
        if (noise) begin
          start_pack = ($urandom_range(0, 3) == 0);
          write_ack  = ($urandom_range(0, 3) == 0);
        end
      end
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        n_checks++;
        $display("FAIL %s timeout: got %0d chunks expected %0d", tag, chunks, TOTAL_CHUNKS);
        break;
      end
    end
    in_valid   = 1'b0;
    write_ack  = 1'b0;
    start_pack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++;
    if (in_addr !== 8'd0) $display("FAIL reset in_addr: got %0d expected 0", in_addr); else n_pass++;
    n_checks++;
    if (write_req !== 1'b0) $display("FAIL reset write_req: got %b expected 0", write_req); else n_pass++;
    n_checks++;
    if (write_addr !== 4'd0) $display("FAIL reset write_addr: got %0d expected 0", write_addr); else n_pass++;
    n_checks++;
    if (write_data !== 128'd0) $display("FAIL reset write_data: got %h expected 0", write_data); else n_pass++;
    n_checks++;
    if (pack_complete !== 1'b0) $display("FAIL reset pack_complete: got %b expected 0", pack_complete); else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL idle in_ready: got %b expected 0", in_ready); else n_pass++;
  endtask

  task automatic test_full_pass();
    run_pass(0, 0, 1'b1, 1'b0, "full_pass");
  endtask

  task automatic test_backpressure();
    run_pass(0, 1, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_bubbles();
    run_pass(1, 0, 1'b0, 1'b0, "bubbles");
  endtask

  // Restart from COMPLETE, with start_pack and write_ack noise during FILL that must be ignored.
  task automatic test_restart_ignore();
    for (int i = 0; i < 3; i++) begin
      write_ack = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pack_complete !== 1'b1) $display("FAIL hold_complete: got %b expected 1", pack_complete); else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL complete_in_ready: got %b expected 0", in_ready); else n_pass++;
    end
    write_ack = 1'b0;
    run_pass(2, 2, 1'b0, 1'b1, "restart_noise");
  endtask

  task automatic test_reset_mid_pass();
    @(negedge clk);
    start_pack = 1'b1;
    @(negedge clk);
    start_pack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (in_addr !== 8'd7) $display("FAIL pre_reset in_addr: got %0d expected 7", in_addr); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL async_reset in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++;
    if (in_addr !== 8'd0) $display("FAIL async_reset in_addr: got %0d expected 0", in_addr); else n_pass++;
    n_checks++;
    if (write_data !== 128'd0) $display("FAIL async_reset write_data: got %h expected 0", write_data); else n_pass++;
    n_checks++;
    if (write_req !== 1'b0 || write_addr !== 4'd0 || pack_complete !== 1'b0)
      $display("FAIL async_reset status: got req %b addr %0d done %b expected 0 0 0", write_req, write_addr, pack_complete);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    run_pass(2, 2, 1'b0, 1'b0, "post_reset");
  endtask

`ifdef CHUNK_PACKER_FLUSH_EN
  task automatic test_flush();
    logic [7:0] fv [3];
    fv[0] = 8'h11; fv[1] = 8'h22; fv[2] = 8'h33;
    @(negedge clk);
    start_pack = 1'b1;
    @(negedge clk);
    start_pack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = fv[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (write_req !== 1'b1) $display("FAIL flush write_req: got %b expected 1", write_req); else n_pass++;
    n_checks++;
    if (write_addr !== 4'd0) $display("FAIL flush write_addr: got %0d expected 0", write_addr); else n_pass++;
    n_checks++;
    if (write_data !== 128'h332211) $display("FAIL flush write_data: got %h expected %h", write_data, 128'h332211); else n_pass++;
    write_ack = 1'b1;
    @(negedge clk);
    write_ack = 1'b0;
    n_checks++;
    if (pack_complete !== 1'b1) $display("FAIL flush complete: got %b expected 1", pack_complete); else n_pass++;
    start_pack = 1'b1;
    @(negedge clk);
    start_pack = 1'b0;
    flush      = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (pack_complete !== 1'b1 || write_req !== 1'b0)
      $display("FAIL empty_flush: got done %b req %b expected 1 0", pack_complete, write_req);
    else n_pass++;
  endtask
`endif

  initial begin
    reset      = 1'b0;
    start_pack = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    write_ack  = 1'b0;
    flush      = 1'b0;
    test_reset();
    test_full_pass();
    test_backpressure();
    test_bubbles();
    test_restart_ignore();
    test_reset_mid_pass();
`ifdef CHUNK_PACKER_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chunk_packer.md
# chunk_packer

Packs a stream of int8 values, one per cycle, into 128-bit chunks and issues one chunk write per 16 values to the chunk-addressed activation memory. It is the write-side counterpart of the flatten stage, which unpacks chunks into a value stream. A producer stage, such as a dense or pooling layer emitting one activation at a time, stores its output through this block. Byte lane ordering matches the unpack side exactly, so a packed chunk read back through flatten reproduces the original value order.

## Interface
Parameters:
- `TOTAL_VALUES`, default 256: values per packing pass.
- `CHUNK_SIZE`, default 16: int8 values per 128-bit chunk. Fixed at 16.
- `TOTAL_CHUNKS`, default `TOTAL_VALUES/CHUNK_SIZE` (16): chunks per pass. `TOTAL_VALUES` must be a multiple of `CHUNK_SIZE`.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start_pack` in 1: begin a pass. Honoured only in IDLE or COMPLETE.
- `in_data` in 8 (`int8_t`): input value.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a value this cycle.
- `in_addr` out `$clog2(TOTAL_VALUES)`: index of the next value to be accepted.
- `write_req` out 1: a chunk write is pending.
- `write_addr` out `$clog2(TOTAL_CHUNKS)`: chunk address of the write.
- `write_data` out 128: packed chunk.
- `write_ack` in 1: memory accepts the write.
- `pack_complete` out 1: the pass is finished.
- `flush` in 1: present only with `CHUNK_PACKER_FLUSH_EN` (see Configuration).

## Operation
States:
- **IDLE**
  - `start_pack` → FILL.
  - `byte_index`, `chunk_addr`, `value_addr` and the buffer are cleared to 0.
- **FILL**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `buffer[byte_index*8 +: 8] <= in_data`, then `byte_index++` and `value_addr++`.
  - When the accepted value has `byte_index`==15 → WRITE.
- **WRITE**
  - `write_req`=1, `in_ready`=0.
  - On `write_ack`, if `chunk_addr`==`TOTAL_CHUNKS-1` → COMPLETE.
  - Otherwise on `write_ack`: → FILL, `chunk_addr++`, `byte_index`=0, buffer cleared to 0.
- **COMPLETE**
  - `pack_complete`=1.
  - `start_pack` → FILL with all counters and the buffer cleared.

Other rules:
- `write_data` is the buffer register; lane i holds the i-th accepted value of the chunk.
- `write_addr` equals `chunk_addr`.
- `in_addr` equals `value_addr`.
- `start_pack` is ignored in FILL and WRITE.
- `in_valid` while `in_ready`=0 is ignored; no data is lost because the producer must hold the value.
- All counters wrap naturally at their widths. No wrap is reachable within a legal pass.

## Timing
- Reset values: `in_ready`=0, `in_addr`=0, `write_req`=0, `write_addr`=0, `write_data`=0, `pack_complete`=0. State is IDLE.
- `start_pack` in cycle N gives `in_ready`=1 in cycle N+1.
- The 16th value of a chunk accepted in cycle N gives `write_req`=1 in N+1.
- `write_req`, `write_addr` and `write_data` are held stable until the cycle in which `write_ack`=1 is sampled.
- `write_ack` in the first WRITE cycle is legal. In that case `in_ready` returns in the following cycle.
- Best-case throughput is 17 cycles per chunk (16 accepts plus 1 write).
- `write_ack` outside WRITE is ignored.
- An asserted `reset` mid-pass aborts immediately to IDLE and drops any partial chunk.

## Configuration
- `CHUNK_PACKER_FLUSH_EN` defined:
  - The `flush` input exists.
  - `flush`=1 in FILL with `byte_index`>0 → WRITE. Unfilled lanes are 0, and after the ack the state goes to COMPLETE.
  - `flush` with `byte_index`==0 in FILL → COMPLETE directly, with no write.
  - If `flush` and an accepted value coincide, the value is stored first and then flushed.
  - `flush` is ignored outside FILL.
- Undefined: no `flush` port. Only full passes of `TOTAL_VALUES` values complete.

## Structure
- The shared `sys_types` package provides `int8_t`.
- The state enum (IDLE, FILL, WRITE, COMPLETE, 2 bits) and `CHUNK_BITS`=128 go in the shared package, alongside the flatten stage's chunk definitions.
- Single module. No sub-module; the lane-write decoder is inline.

## Test plan
- Full pass:
  - Stimulus: `start_pack`, then values 0..255 streamed with `in_valid` held high, and `write_ack` returned in the same cycle as `write_req`.
  - Required response: 16 writes at addresses 0..15. Chunk 0 `write_data` = 128'h0F0E…0100. `pack_complete` high after the write to address 15.
- Back-pressure:
  - Stimulus: `write_ack` delayed 5 cycles.
  - Required response: `write_req`, `write_addr` and `write_data` stay stable throughout; `in_ready`=0; an extra value offered during the wait is not consumed.
- Bubbles:
  - Stimulus: `in_valid` toggled 1,0,1,…
  - Required response: `in_addr` increments only on accepted values; chunk contents are still in order.
- Reset mid-pass:
  - Stimulus: assert `reset` after 7 values, release it, then run a new pass.
  - Required response: all outputs go to 0 asynchronously. The new pass's first write is at address 0 and contains no stale bytes.
- Restart and ignore rules:
  - Stimulus: `start_pack` in COMPLETE; separately, `start_pack` asserted during FILL.
  - Required response: in COMPLETE, `in_ready`=1 next cycle with `in_addr`=0. During FILL, `start_pack` is ignored and counters continue.
- Flush (with `CHUNK_PACKER_FLUSH_EN`):
  - Stimulus: `flush` after 3 values 0x11, 0x22, 0x33.
  - Required response: a write to address 0 with `write_data` = 128'h…00332211, then `pack_complete`.
